// File: rtl/fig_14_cache_fill_ctrl_pkg.sv
// rtl/fig_14_cache_fill_ctrl_pkg.sv - shared geometry constants and FSM encoding for the cache fill controller
//
// Geometry: LINES lines of LINE_BYTES bytes each, giving a window of
// LINES*LINE_BYTES bytes above the cache base register. The derived widths
// are the line index (5), the byte offset (4) and the cache RAM address (9).
package fig_14_cache_fill_ctrl_pkg;

    localparam int LINES      = 32;
    localparam int LINE_BYTES = 16;
    localparam int ADDR_W     = 16;

    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int LINE_W     = $clog2(LINES);
    localparam int CADDR_W    = LINE_W + OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_SETV   = 3'd3,
        ST_DIRECT = 3'd4
    } state_t;

    function automatic logic [LINES-1:0] line_onehot(input logic [LINE_W-1:0] line);
        return {{(LINES-1){1'b0}}, 1'b1} << line;
    endfunction

endpackage

// File: rtl/fig_14_cache_fill_ctrl_if.sv
// rtl/fig_14_cache_fill_ctrl_if.sv - fetch and memory-bus handshakes of the cache fill controller
//
// Fetch side : fetch_req/fetch_addr in, fetch_ack/fetch_data out (to the controller).
// Memory side: mem_req/mem_addr out, mem_ack/mem_data in (to the controller).
// master = the controller, slave = the fetch unit plus memory system.
interface fig_14_cache_fill_ctrl_if;
    import fig_14_cache_fill_ctrl_pkg::*;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [7:0]        fetch_data;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (
        input  fetch_req, fetch_addr, mem_ack, mem_data,
        output fetch_ack, fetch_data, mem_req, mem_addr
    );

    modport slave (
        output fetch_req, fetch_addr, mem_ack, mem_data,
        input  fetch_ack, fetch_data, mem_req, mem_addr
    );

endinterface

// File: rtl/fig_14_fill_counter.sv
// rtl/fig_14_fill_counter.sv - line offset counter for a cache fill, with start load and modulo wrap
//
// Ports: clk, rst (async, active-high); load/start begin a fill at offset
// start; adv steps to the next byte; cnt is the current byte offset (wraps
// modulo 2**W); done is high while the last byte of the line is current.
module fig_14_fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] start,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         done
);

    // beats counts transferred bytes independently of the (possibly rotated)
    // offset, so the end of the line is found wherever the fill started.
    logic [W-1:0] beats;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            beats <= '0;
        end else if (load) begin
            cnt   <= start;
            beats <= '0;
        end else if (adv) begin
            cnt   <= cnt + 1'b1;
            beats <= beats + 1'b1;
        end
    end

    assign done = &beats;

endmodule

// File: rtl/fig_14_cache_fill_ctrl.sv
// rtl/fig_14_cache_fill_ctrl.sv - instruction-cache lookup/fill controller feeding the valid-bit block
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus (master)        fetch_req/addr -> fetch_ack/data; mem_req/addr -> mem_ack/data
//   flush               one-cycle flush pulse; registered onto clr
//   cbr                 cache base register (low offset bits ignored)
//   valid_bits          line-valid bits from the valid-bit block
//   set, selector       one-cycle pulse + one-hot line to mark a filled line valid
//   clr                 clears all valid bits (flush delayed one cycle)
//   cache_raddr/rdata   cache RAM read port (1-cycle synchronous read)
//   cache_we/waddr/wdata cache RAM write port, waddr = {line, offset}
// Build option: CACHE_CRITICAL_FIRST_EN starts each fill at the requested
// byte and wraps around the line, so the fetch is answered on the first beat.
module fig_14_cache_fill_ctrl
    import fig_14_cache_fill_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    fig_14_cache_fill_ctrl_if.master bus,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     cbr,
    input  logic [LINES-1:0]      valid_bits,
    output logic                  set,
    output logic [LINES-1:0]      selector,
    output logic                  clr,
    output logic [CADDR_W-1:0]    cache_raddr,
    input  logic [7:0]            cache_rdata,
    output logic                  cache_we,
    output logic [CADDR_W-1:0]    cache_waddr,
    output logic [7:0]            cache_wdata
);

    state_t                 state;
    logic [LINE_W-1:0]      line_q;
    logic [OFF_W-1:0]       byte_q;
    logic [ADDR_W-OFF_W-1:0] base_hi_q;
    logic [7:0]             fetch_data_q;
    logic                   hit_rd_q;

    logic [ADDR_W-1:0]      cbr_base;
    logic [ADDR_W-1:0]      off;
    logic                   in_win;
    logic [LINE_W-1:0]      req_line;
    logic [OFF_W-1:0]       req_byte;
    logic [OFF_W-1:0]       start_off;
    logic                   hit;

    logic                   cnt_load;
    logic                   cnt_adv;
    logic [OFF_W-1:0]       fill_cnt;
    logic                   fill_done;

    assign cbr_base = cbr & ~ADDR_W'(LINE_BYTES - 1);
    assign off      = bus.fetch_addr - cbr_base;
    // The window is a power of two, so "off < window" is just "upper bits zero";
    // addresses below cbr wrap to large offsets and fall outside.
    assign in_win   = (off[ADDR_W-1:CADDR_W] == '0);
    assign req_line = off[CADDR_W-1:OFF_W];
    assign req_byte = off[OFF_W-1:0];
    assign hit      = valid_bits[req_line];

`ifdef CACHE_CRITICAL_FIRST_EN
    assign start_off = req_byte;
`else
    assign start_off = '0;
`endif

    assign cnt_load = (state == ST_IDLE) && bus.fetch_req && in_win && !hit && !flush;
    assign cnt_adv  = (state == ST_FILL) && bus.mem_req && bus.mem_ack && !flush;

    fig_14_fill_counter #(.W(OFF_W)) u_fill_counter (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .start (start_off),
        .adv   (cnt_adv),
        .cnt   (fill_cnt),
        .done  (fill_done)
    );

    // A hit returns the RAM output directly: the read is launched on entry to
    // LOOKUP and the data lands in the same cycle fetch_ack is raised.
    assign bus.fetch_data = hit_rd_q ? cache_rdata : fetch_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            line_q        <= '0;
            byte_q        <= '0;
            base_hi_q     <= '0;
            fetch_data_q  <= '0;
            hit_rd_q      <= 1'b0;
            bus.fetch_ack <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            set           <= 1'b0;
            selector      <= '0;
            clr           <= 1'b0;
            cache_raddr   <= '0;
            cache_we      <= 1'b0;
            cache_waddr   <= '0;
            cache_wdata   <= '0;
        end else begin
            bus.fetch_ack <= 1'b0;
            set           <= 1'b0;
            selector      <= '0;
            cache_we      <= 1'b0;
            clr           <= flush;

            if (flush) begin
                // Abandon whatever is in flight; a late mem_ack then arrives
                // in IDLE where it is ignored, and the line is never marked.
                state       <= ST_IDLE;
                bus.mem_req <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.fetch_req) begin
                            line_q    <= req_line;
                            byte_q    <= req_byte;
                            base_hi_q <= bus.fetch_addr[ADDR_W-1:OFF_W];
                            if (!in_win) begin
                                bus.mem_req  <= 1'b1;
                                bus.mem_addr <= bus.fetch_addr;
                                state        <= ST_DIRECT;
                            end else if (hit) begin
                                cache_raddr <= off[CADDR_W-1:0];
                                state       <= ST_LOOKUP;
                            end else begin
                                bus.mem_req  <= 1'b1;
                                bus.mem_addr <= {bus.fetch_addr[ADDR_W-1:OFF_W], start_off};
                                state        <= ST_FILL;
                            end
                        end
                    end

                    ST_LOOKUP: begin
                        bus.fetch_ack <= 1'b1;
                        hit_rd_q      <= 1'b1;
                        state         <= ST_IDLE;
                    end

                    ST_FILL: begin
                        if (bus.mem_req && bus.mem_ack) begin
                            bus.mem_req <= 1'b0;
                            cache_we    <= 1'b1;
                            cache_waddr <= {line_q, fill_cnt};
                            cache_wdata <= bus.mem_data;
                            if (fill_cnt == byte_q) begin
                                bus.fetch_ack <= 1'b1;
                                fetch_data_q  <= bus.mem_data;
                                hit_rd_q      <= 1'b0;
                            end
                            if (fill_done) begin
                                state <= ST_SETV;
                            end
                        end else if (!bus.mem_req) begin
                            // One idle cycle after each ack, then the next byte;
                            // fill_cnt has already stepped past the acked byte.
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {base_hi_q, fill_cnt};
                        end
                    end

                    ST_SETV: begin
                        // Entered one cycle after the last write, so set never
                        // overlaps cache_we.
                        set      <= 1'b1;
                        selector <= line_onehot(line_q);
                        state    <= ST_IDLE;
                    end

                    ST_DIRECT: begin
                        if (bus.mem_req && bus.mem_ack) begin
                            bus.mem_req   <= 1'b0;
                            bus.fetch_ack <= 1'b1;
                            fetch_data_q  <= bus.mem_data;
                            hit_rd_q      <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fig_14_cache_fill_ctrl.sv
// tb/tb_fig_14_cache_fill_ctrl.sv - scoreboard bench for the cache fill controller
module tb_fig_14_cache_fill_ctrl;
    import fig_14_cache_fill_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] cbr = 16'h8000;
    logic [31:0] valid_bits;
    logic        set;
    logic [31:0] selector;
    logic        clr;
    logic [8:0]  cache_raddr;
    logic [7:0]  cache_rdata;
    logic        cache_we;
    logic [8:0]  cache_waddr;
    logic [7:0]  cache_wdata;

    fig_14_cache_fill_ctrl_if bus();

    fig_14_cache_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flush       (flush),
        .cbr         (cbr),
        .valid_bits  (valid_bits),
        .set         (set),
        .selector    (selector),
        .clr         (clr),
        .cache_raddr (cache_raddr),
        .cache_rdata (cache_rdata),
        .cache_we    (cache_we),
        .cache_waddr (cache_waddr),
        .cache_wdata (cache_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:511];
    always @(posedge clk) begin
        if (cache_we) ram[cache_waddr] <= cache_wdata;
        cache_rdata <= ram[cache_raddr];
    end

    always @(posedge clk or posedge rst) begin
        if (rst)      valid_bits <= '0;
        else if (clr) valid_bits <= '0;
        else if (set) valid_bits <= valid_bits | selector;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q_maddr [$];
    logic [16:0] q_wr    [$];
    logic [7:0]  q_data  [$];
    logic [31:0] q_set   [$];

    int lat = 2, wait_cnt = 0, ack_num = 0, flush_at = 0, late_cnt = 0;
    int we_cnt = 0, set_cnt = 0, clr_cnt = 0, ack_at_fack = 0, we_at_set = 0;
    bit fack_seen = 0;

`ifdef CACHE_CRITICAL_FIRST_EN
    localparam bit CRIT = 1'b1;
`else
    localparam bit CRIT = 1'b0;
`endif

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // One clock: memory responder drives after the edge, monitor checks at negedge.
    task automatic step();
        logic [15:0] ea;
        logic [16:0] ew;
        logic [7:0]  ed;
        logic [31:0] es;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (late_cnt > 0) begin
            late_cnt--;
            if (late_cnt == 0) begin
                bus.mem_data = 8'hEE;
                bus.mem_ack  = 1'b1;
            end
        end else if (bus.mem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                wait_cnt = 0;
                lat = $urandom_range(1, 3);
                ack_num++;
                n_cmp++;
                if (q_maddr.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem_addr: unexpected read at %h, none required", bus.mem_addr);
                end else begin
                    ea = q_maddr.pop_front();
                    if (bus.mem_addr !== ea) begin
                        n_bad++;
                        $display("FAIL mem_addr: got %h required %h", bus.mem_addr, ea);
                    end
                end
                bus.mem_data = mem_byte(bus.mem_addr);
                bus.mem_ack  = 1'b1;
                if (ack_num == flush_at) begin
                    flush    = 1'b1;
                    late_cnt = 3;
                end
            end
        end
        @(negedge clk);
        if (bus.fetch_ack) begin
            fack_seen   = 1'b1;
            ack_at_fack = ack_num;
            n_cmp++;
            if (q_data.size() == 0) begin
                n_bad++;
                $display("FAIL fetch_ack: unexpected ack data %h", bus.fetch_data);
            end else begin
                ed = q_data.pop_front();
                if (bus.fetch_data !== ed) begin
                    n_bad++;
                    $display("FAIL fetch_data: got %h required %h", bus.fetch_data, ed);
                end
            end
        end
        if (cache_we) begin
            we_cnt++;
            n_cmp++;
            if (q_wr.size() == 0) begin
                n_bad++;
                $display("FAIL cache_we: unexpected write %h=%h", cache_waddr, cache_wdata);
            end else begin
                ew = q_wr.pop_front();
                if ({cache_waddr, cache_wdata} !== ew) begin
                    n_bad++;
                    $display("FAIL cache_write: got %h required %h", {cache_waddr, cache_wdata}, ew);
                end
            end
        end
        if (set) begin
            set_cnt++;
            we_at_set = we_cnt;
            n_cmp++;
            if (q_set.size() == 0) begin
                n_bad++;
                $display("FAIL set: unexpected set selector %h", selector);
            end else begin
                es = q_set.pop_front();
                if (selector !== es) begin
                    n_bad++;
                    $display("FAIL selector: got %h required %h", selector, es);
                end
            end
        end
        if (clr) clr_cnt++;
        n_cmp++;
        if ((set && cache_we) || (!set && selector !== 32'h0)) begin
            n_bad++;
            $display("FAIL set_protocol: set=%b we=%b selector=%h", set, cache_we, selector);
        end
    endtask

    task automatic push_fill(input logic [15:0] addr);
        logic [15:0] off, base;
        logic [4:0]  line;
        logic [3:0]  st, o;
        off  = addr - cbr;
        line = off[8:4];
        base = {addr[15:4], 4'h0};
        st   = CRIT ? addr[3:0] : 4'h0;
        for (int i = 0; i < 16; i++) begin
            o = st + 4'(i);
            q_maddr.push_back(base | {12'h0, o});
            q_wr.push_back({line, o, mem_byte(base | {12'h0, o})});
        end
        q_data.push_back(mem_byte(addr));
        q_set.push_back(32'h1 << line);
    endtask

    task automatic do_fetch(input logic [15:0] addr, output int cyc);
        fack_seen      = 1'b0;
        bus.fetch_addr = addr;
        bus.fetch_req  = 1'b1;
        cyc = 0;
        while (!fack_seen && cyc < 300) begin
            step();
            cyc++;
        end
        bus.fetch_req = 1'b0;
        n_cmp++;
        if (!fack_seen) begin
            n_bad++;
            $display("FAIL fetch_timeout: no fetch_ack for %h after %0d cycles", addr, cyc);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((q_maddr.size() + q_wr.size() + q_data.size() + q_set.size()) != 0 && k < 300) begin
            step();
            k++;
        end
        repeat (4) step();
        n_cmp++;
        if ((q_maddr.size() + q_wr.size() + q_data.size() + q_set.size()) != 0) begin
            n_bad++;
            $display("FAIL drain: %0d reads %0d writes %0d acks %0d sets outstanding, required 0",
                     q_maddr.size(), q_wr.size(), q_data.size(), q_set.size());
        end
    endtask

    task automatic test_reset();
        bus.fetch_req = 1'b0; bus.fetch_addr = '0; bus.mem_ack = 1'b0; bus.mem_data = '0;
        repeat (2) step();
        n_cmp++;
        if ({bus.fetch_ack, bus.fetch_data, bus.mem_req, bus.mem_addr, set, selector, clr,
             cache_raddr, cache_we, cache_waddr, cache_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: some output nonzero under reset, required all 0");
        end
        rst = 1'b0;
        repeat (2) step();
        n_cmp++;
        if ({bus.fetch_ack, bus.mem_req, set, clr, cache_we} !== 5'b0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %b required 00000", {bus.fetch_ack, bus.mem_req, set, clr, cache_we});
        end
    endtask

    task automatic test_fill();
        int cyc, w0, s0;
        w0 = we_cnt; s0 = set_cnt; ack_num = 0;
        push_fill(16'h8013);
        do_fetch(16'h8013, cyc);
        n_cmp++;
        if (ack_at_fack !== (CRIT ? 1 : 4)) begin
            n_bad++;
            $display("FAIL fill_ack_beat: got %0d required %0d", ack_at_fack, CRIT ? 1 : 4);
        end
        drain();
        n_cmp++;
        if (we_at_set - w0 !== 16 || set_cnt - s0 !== 1) begin
            n_bad++;
            $display("FAIL fill_set: writes before set %0d sets %0d, required 16 and 1", we_at_set - w0, set_cnt - s0);
        end
        n_cmp++;
        if (valid_bits[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_valid: valid_bits %h, required bit 1 set", valid_bits);
        end
    endtask

    task automatic test_hit();
        int cyc, a0;
        a0 = ack_num;
        q_data.push_back(mem_byte(16'h8013));
        do_fetch(16'h8013, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL hit_latency: got %0d required 2", cyc);
        end
        drain();
        n_cmp++;
        if (ack_num !== a0) begin
            n_bad++;
            $display("FAIL hit_memreads: got %0d required 0", ack_num - a0);
        end
    endtask

    task automatic test_direct();
        int cyc, w0, s0;
        w0 = we_cnt; s0 = set_cnt;
        q_maddr.push_back(16'h9000);
        q_data.push_back(mem_byte(16'h9000));
        do_fetch(16'h9000, cyc);
        drain();
        n_cmp++;
        if (we_cnt !== w0 || set_cnt !== s0) begin
            n_bad++;
            $display("FAIL direct_side_effects: writes %0d sets %0d, required 0 and 0", we_cnt - w0, set_cnt - s0);
        end
    endtask

    task automatic test_flush();
        int k, cyc, w0, s0, c0;
        w0 = we_cnt; s0 = set_cnt; c0 = clr_cnt; ack_num = 0;
        for (int i = 0; i < 6; i++) q_maddr.push_back(16'h8020 + 16'(i));
        for (int i = 0; i < 5; i++) q_wr.push_back({5'd2, 4'(i), mem_byte(16'h8020 + 16'(i))});
        flush_at = 6;
        bus.fetch_addr = 16'h802F;
        bus.fetch_req  = 1'b1;
        k = 0;
        while (ack_num < 6 && k < 300) begin
            step();
            k++;
        end
        bus.fetch_req = 1'b0;
        step();
        n_cmp++;
        if (clr !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_abort: clr=%b mem_req=%b, required 1 and 0", clr, bus.mem_req);
        end
        repeat (8) step();
        flush_at = 0;
        n_cmp++;
        if (q_maddr.size() !== 0 || q_wr.size() !== 0 || we_cnt - w0 !== 5) begin
            n_bad++;
            $display("FAIL flush_traffic: reads left %0d writes %0d, required 0 and 5", q_maddr.size(), we_cnt - w0);
        end
        n_cmp++;
        if (set_cnt !== s0 || clr_cnt - c0 !== 1 || valid_bits !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_set: sets %0d clr pulses %0d valid %h, required 0 1 00000000",
                     set_cnt - s0, clr_cnt - c0, valid_bits);
        end
        push_fill(16'h802F);
        do_fetch(16'h802F, cyc);
        drain();
        n_cmp++;
        if (valid_bits !== 32'h4) begin
            n_bad++;
            $display("FAIL flush_refill: valid %h required 00000004", valid_bits);
        end
    endtask

    task automatic test_critical_first();
        int cyc, w0;
        w0 = we_cnt; ack_num = 0;
        push_fill(16'h801E);
        do_fetch(16'h801E, cyc);
        n_cmp++;
        if (ack_at_fack !== (CRIT ? 1 : 15)) begin
            n_bad++;
            $display("FAIL crit_ack_beat: got %0d required %0d", ack_at_fack, CRIT ? 1 : 15);
        end
        drain();
        n_cmp++;
        if (we_at_set - w0 !== 16 || valid_bits[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL crit_set: writes before set %0d valid %h, required 16 and bit 1", we_at_set - w0, valid_bits);
        end
    endtask

    task automatic test_rst_mid_fill();
        int k, cyc, s0;
        s0 = set_cnt; ack_num = 0;
        push_fill(16'h8043);
        bus.fetch_addr = 16'h8043;
        bus.fetch_req  = 1'b1;
        k = 0;
        while (ack_num < 3 && k < 300) begin
            step();
            k++;
        end
        #2 rst = 1'b1;
        bus.fetch_req = 1'b0;
        bus.mem_ack   = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fetch_ack, bus.fetch_data, bus.mem_req, bus.mem_addr, set, selector, clr,
             cache_raddr, cache_we, cache_waddr, cache_wdata} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: outputs not cleared immediately, mem_req=%b mem_addr=%h", bus.mem_req, bus.mem_addr);
        end
        q_maddr.delete(); q_wr.delete(); q_data.delete(); q_set.delete();
        wait_cnt = 0; late_cnt = 0;
        step();
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (set_cnt !== s0 || valid_bits[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_line: sets %0d valid %h, required 0 and bit 4 clear", set_cnt - s0, valid_bits);
        end
        ack_num = 0;
        push_fill(16'h8043);
        do_fetch(16'h8043, cyc);
        drain();
        n_cmp++;
        if (set_cnt - s0 !== 1 || valid_bits[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_refill: sets %0d valid %h, required 1 and bit 4 set", set_cnt - s0, valid_bits);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_direct();
        test_flush();
        test_critical_first();
        test_rst_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
